// File: rtl/mem_client_pkg.sv
// Shared types for the memory-farm read client: line geometry, FSM states and
// the return-buffer entry layout.
package mem_client_pkg;

    localparam int unsigned LINE_BYTES = 32;
    localparam int unsigned SIZE_W     = 5;
    localparam int unsigned NBYTES_W   = SIZE_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN,
        DONE
    } rd_client_state_e;

    typedef struct packed {
        logic [8*LINE_BYTES-1:0] data;
        logic [NBYTES_W-1:0]     nbytes;
        logic                    last;
    } rd_line_s;

endpackage

// File: rtl/mem_client_fifo.sv
// Synchronous line buffer with first-word fall-through head and occupancy outputs.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module mem_client_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] free
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = cnt;
    assign free    = CNT_W'(DEPTH) - cnt;
    // Head is forced to zero while empty so the stream outputs idle at zero.
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)
                cnt <= cnt + CNT_W'(1);
            else if (do_pop && !do_push)
                cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mem_read_client.sv
// Splits one read job into <=32-byte line requests, buffers returned lines and
// streams them out. Optional watchdog on farm responses: MEM_READ_CLIENT_TIMEOUT_EN.
module mem_read_client
    import mem_client_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned LINE_BYTES = 32,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    job_start,
    input  logic [ADDR_WIDTH-1:0]   job_addr,
    input  logic [LEN_WIDTH-1:0]    job_len,
    output logic                    job_busy,
    output logic                    job_done,
    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_start_addr,
    output logic [4:0]              mem_size_bytes,
    input  logic                    mem_valid,
    input  logic [8*LINE_BYTES-1:0] mem_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*LINE_BYTES-1:0] out_data,
    output logic [5:0]              out_bytes,
    output logic                    out_last
`ifdef MEM_READ_CLIENT_TIMEOUT_EN
    ,
    output logic                    err_timeout
`endif
);

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENTRY_W = $bits(rd_line_s);

    rd_client_state_e      state;
    rd_client_state_e      state_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [NBYTES_W-1:0]   chunk;
    logic                  last_line;
    logic                  accept_line;
    logic                  pop;
    logic                  timeout;
    rd_line_s              push_entry;
    rd_line_s              head_entry;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      fifo_free;

    assign chunk       = (remaining >= LEN_WIDTH'(LINE_BYTES)) ? NBYTES_W'(LINE_BYTES)
                                                               : remaining[NBYTES_W-1:0];
    assign last_line   = (remaining <= LEN_WIDTH'(LINE_BYTES));
    assign accept_line = (state == WAIT) && mem_valid;
    assign pop         = !fifo_empty && out_ready;

    assign push_entry = '{data: mem_data, nbytes: chunk, last: last_line};

    mem_client_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (timeout),
        .push      (accept_line),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .free      (fifo_free)
    );

`ifdef MEM_READ_CLIENT_TIMEOUT_EN
    logic [9:0] wait_cnt;

    assign timeout = (state == WAIT) && !mem_valid && (wait_cnt == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state == WAIT && !mem_valid)
                wait_cnt <= wait_cnt + 10'd1;
            else
                wait_cnt <= '0;
            if (timeout)
                err_timeout <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (job_start) state_nxt = (job_len == '0) ? DONE : ISSUE;
            // Free count is taken before this cycle's pop; one request is
            // outstanding at most, so the FIFO cannot overflow.
            ISSUE: if (fifo_free != '0) state_nxt = WAIT;
            WAIT: begin
                if (mem_valid)    state_nxt = last_line ? DRAIN : ISSUE;
                else if (timeout) state_nxt = DONE;
            end
            // The last line is the only entry left when it is accepted.
            DRAIN: if (pop && head_entry.last && fifo_count == CNT_W'(1)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        job_busy       = (state != IDLE);
        job_done       = (state == DONE);
        mem_req        = 1'b0;
        mem_start_addr = '0;
        mem_size_bytes = '0;
        if (state == WAIT) begin
            mem_req        = 1'b1;
            mem_start_addr = cur_addr;
            mem_size_bytes = SIZE_W'(chunk - NBYTES_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr  <= '0;
            remaining <= '0;
        end else if (state == IDLE && job_start) begin
            cur_addr  <= job_addr;
            remaining <= job_len;
        end else if (accept_line) begin
            cur_addr  <= cur_addr + ADDR_WIDTH'(chunk);
            remaining <= remaining - LEN_WIDTH'(chunk);
        end
    end

    assign out_valid = !fifo_empty;
    assign out_data  = head_entry.data;
    assign out_bytes = head_entry.nbytes;
    assign out_last  = head_entry.last;

endmodule

// File: tb/tb_mem_read_client.sv
// Randomised scoreboard bench for mem_read_client: a job model predicts line
// requests and stream beats; a farm model answers requests, a monitor checks beats.
module tb_mem_read_client;

    typedef struct {
        logic [18:0] addr;
        logic [4:0]  size;
    } req_t;

    typedef struct {
        logic [255:0] data;
        logic [5:0]   nb;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         job_start;
    logic [18:0]  job_addr;
    logic [15:0]  job_len;
    logic         job_busy;
    logic         job_done;
    logic         mem_req;
    logic [18:0]  mem_start_addr;
    logic [4:0]   mem_size_bytes;
    logic         mem_valid;
    logic [255:0] mem_data;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic [5:0]   out_bytes;
    logic         out_last;
`ifdef MEM_READ_CLIENT_TIMEOUT_EN
    logic         err_timeout;
`endif

    req_t  exp_reqs[$];
    beat_t exp_beats[$];
    int    total = 0;
    int    bad = 0;
    int    farm_delay = 1;
    int    ready_mode = 0;
    int    req_cnt = 0;
    int    done_cnt = 0;
    int    busy_cnt = 0;
    int unsigned edge_lens [4];

    always #5 clk = ~clk;

    mem_read_client #(
        .ADDR_WIDTH (19),
        .LINE_BYTES (32),
        .LEN_WIDTH  (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .job_start      (job_start),
        .job_addr       (job_addr),
        .job_len        (job_len),
        .job_busy       (job_busy),
        .job_done       (job_done),
        .mem_req        (mem_req),
        .mem_start_addr (mem_start_addr),
        .mem_size_bytes (mem_size_bytes),
        .mem_valid      (mem_valid),
        .mem_data       (mem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_bytes      (out_bytes),
        .out_last       (out_last)
`ifdef MEM_READ_CLIENT_TIMEOUT_EN
        ,
        .err_timeout    (err_timeout)
`endif
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Farm contents: each byte is a fixed function of its own SRAM address.
    function automatic logic [255:0] line_of(input logic [18:0] a);
        logic [255:0] d;
        logic [18:0]  b;
        d = '0;
        for (int k = 0; k < 32; k++) begin
            b = a + 19'(k);
            d[8*k +: 8] = b[7:0] ^ b[15:8] ^ {b[18:16], 5'b10101};
        end
        return d;
    endfunction

    task automatic model_job(input logic [18:0] a, input int unsigned len);
        int unsigned off;
        int unsigned c;
        req_t  r;
        beat_t bt;
        off = 0;
        while (off < len) begin
            c = (len - off > 32) ? 32 : len - off;
            r.addr  = a + 19'(off);
            r.size  = 5'(c - 1);
            bt.data = line_of(r.addr);
            bt.nb   = 6'(c);
            bt.last = (off + c == len);
            exp_reqs.push_back(r);
            exp_beats.push_back(bt);
            off += c;
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".mem_req"},   mem_req, 0);
        chk({tag, ".job_busy"},  job_busy, 0);
        chk({tag, ".job_done"},  job_done, 0);
        chk({tag, ".req_addr"},  mem_start_addr, 0);
        chk({tag, ".req_size"},  mem_size_bytes, 0);
        chk({tag, ".out_valid"}, out_valid, 0);
        chk({tag, ".out_data"},  out_data, 0);
        chk({tag, ".out_bytes"}, out_bytes, 0);
        chk({tag, ".out_last"},  out_last, 0);
    endtask

    task automatic start_job(input logic [18:0] a, input int unsigned len);
        model_job(a, len);
        @(posedge clk); #1;
        job_addr  = a;
        job_len   = 16'(len);
        job_start = 1'b1;
        @(posedge clk); #1;
        job_start = 1'b0;
    endtask

    task automatic finish_job(input string name, input int d0, input int r0, input int unsigned lines);
        int unsigned i;
        i = 0;
        while (done_cnt == d0 && i < 3000) begin
            @(posedge clk); #1;
            i++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({name, ".done_once"},   done_cnt - d0, 1);
        chk({name, ".req_count"},   req_cnt - r0, lines);
        chk({name, ".beats_left"},  exp_beats.size(), 0);
        chk({name, ".reqs_left"},   exp_reqs.size(), 0);
        chk({name, ".idle_busy"},   job_busy, 0);
    endtask

    task automatic run_job(input string name, input logic [18:0] a, input int unsigned len,
                           input bit spur);
        int d0;
        int r0;
        int b0;
        d0 = done_cnt;
        r0 = req_cnt;
        b0 = busy_cnt;
        start_job(a, len);
        if (spur) begin
            @(posedge clk); #1;
            job_addr  = 19'h05555;
            job_len   = 16'd7;
            job_start = 1'b1;
            @(posedge clk); #1;
            job_start = 1'b0;
        end
        finish_job(name, d0, r0, (len + 31) / 32);
        if (len == 0) chk({name, ".busy_cycles"}, busy_cnt - b0, 1);
    endtask

    // Farm responder and request checker.
    initial begin
        int   cnt;
        int   held;
        logic pend;
        req_t cur;
        req_t e;
        pend      = 1'b0;
        cnt       = 0;
        held      = 0;
        mem_valid = 1'b0;
        mem_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend      = 1'b0;
                mem_valid = 1'b0;
            end else if (mem_valid) begin
                chk("req_drop_after_return", mem_req, 0);
                mem_valid = 1'b0;
            end else if (mem_req) begin
                if (!pend) begin
                    pend     = 1'b1;
                    cnt      = farm_delay;
                    held     = 0;
                    req_cnt++;
                    cur.addr = mem_start_addr;
                    cur.size = mem_size_bytes;
                    if (exp_reqs.size() == 0) begin
                        chk("unexpected_req", 1, 0);
                    end else begin
                        e = exp_reqs.pop_front();
                        chk("req_addr", cur.addr, e.addr);
                        chk("req_size", cur.size, e.size);
                    end
                end else begin
                    chk("req_addr_stable", mem_start_addr, cur.addr);
                    chk("req_size_stable", mem_size_bytes, cur.size);
                end
                held++;
                if (cnt == 0) begin
                    chk("req_hold_cycles", held, farm_delay + 1);
                    mem_valid = 1'b1;
                    mem_data  = line_of(cur.addr);
                    pend      = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (pend) begin
                chk("req_dropped_early", 0, 1);
                pend = 1'b0;
            end
        end
    end

    // Stream monitor.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (job_done) done_cnt++;
                if (job_busy) busy_cnt++;
                if (out_valid && out_ready) begin
                    if (exp_beats.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        b = exp_beats.pop_front();
                        chk("beat_data",  out_data, b.data);
                        chk("beat_bytes", out_bytes, b.nb);
                        chk("beat_last",  out_last, b.last);
                    end
                end
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int r0;
        int unsigned i;
        logic [18:0] a;
        int unsigned len;

        rst       = 1'b1;
        job_start = 1'b0;
        job_addr  = '0;
        job_len   = '0;
        edge_lens[0] = 1;
        edge_lens[1] = 31;
        edge_lens[2] = 32;
        edge_lens[3] = 33;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        farm_delay = 1;
        run_job("job96", 19'h00100, 96, 1'b1);
        run_job("job40", 19'h00200, 40, 1'b0);
        run_job("job0",  19'h00300, 0,  1'b0);
        for (int k = 0; k < 4; k++) run_job("edge_len", 19'h00500 + 19'(k * 64), edge_lens[k], 1'b0);

        ready_mode = 2;
        d0 = done_cnt;
        r0 = req_cnt;
        start_job(19'h01000, 256);
        repeat (40) @(posedge clk);
        #1;
        chk("bp.req_while_full", req_cnt - r0, 4);
        chk("bp.mem_req_low",    mem_req, 0);
        chk("bp.out_valid",      out_valid, 1);
        ready_mode = 0;
        finish_job("bp", d0, r0, 8);

        farm_delay = 7;
        run_job("slow_farm", 19'h00400, 100, 1'b0);
        farm_delay = 1;
        run_job("wrap", 19'h7FFE0, 64, 1'b0);

        farm_delay = 7;
        start_job(19'h02000, 256);
        i = 0;
        while (!mem_req && i < 20) begin
            @(posedge clk); #1;
            i++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst.mid_wait", mem_req, 1);
        rst = 1'b1;
        #1;
        chk_idle_outputs("rst_wait");
        exp_reqs.delete();
        exp_beats.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        farm_delay = 1;
        run_job("after_rst", 19'h00040, 33, 1'b0);

        for (int j = 0; j < 20; j++) begin
            farm_delay = int'($urandom_range(0, 4));
            ready_mode = int'($urandom_range(0, 1));
            a   = 19'($urandom);
            len = $urandom_range(0, 300);
            run_job("rand", a, len, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
